// File: rtl/sw_debounce2.sv
// Two-channel switch conditioner: 2-flop sync, per-channel stability counter, clean levels and edge strobes.
// Optional macro SW_TOGGLE_EN turns a/b into toggle latches flipped by each debounced rising edge.
module sw_debounce2 #(
  parameter int CNT_W      = 20,
  parameter int STABLE_CNT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_a_in,
  input  logic sw_b_in,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic chg
);

  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  // Index 0 is channel A, index 1 is channel B.
  logic [1:0]       s1_p0;
  logic [1:0]       s2_p1;
  state_t           st_p2     [2];
  state_t           st_nxt    [2];
  logic [CNT_W-1:0] cnt_p2    [2];
  logic [CNT_W-1:0] cnt_nxt   [2];
  logic [1:0]       rise_nxt;
  logic [1:0]       fall_nxt;
  logic [1:0]       rise_p2;
  logic [1:0]       fall_p2;
  logic             chg_p2;

  function automatic logic at_limit(input logic [CNT_W-1:0] c);
    return c == CNT_LAST;
  endfunction

  // Stage 0/1: two-flop synchroniser for the raw switch levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p0 <= 2'b00;
      s2_p1 <= 2'b00;
    end else begin
      s1_p0 <= {sw_b_in, sw_a_in};
      s2_p1 <= s1_p0;
    end
  end

  // Stage 2: per-channel stability FSM; any contrary-free cycle clears the counter
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_nxt[i]   = st_p2[i];
      cnt_nxt[i]  = '0;
      rise_nxt[i] = 1'b0;
      fall_nxt[i] = 1'b0;
      case (st_p2[i])
        LOW: begin
          if (s2_p1[i]) begin
            if (at_limit(cnt_p2[i])) begin
              st_nxt[i]   = HIGH;
              rise_nxt[i] = 1'b1;
            end else begin
              cnt_nxt[i] = cnt_p2[i] + CNT_W'(1);
            end
          end
        end
        HIGH: begin
          if (!s2_p1[i]) begin
            if (at_limit(cnt_p2[i])) begin
              st_nxt[i]   = LOW;
              fall_nxt[i] = 1'b1;
            end else begin
              cnt_nxt[i] = cnt_p2[i] + CNT_W'(1);
            end
          end
        end
        default: st_nxt[i] = LOW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        st_p2[i]  <= LOW;
        cnt_p2[i] <= '0;
      end
      rise_p2 <= 2'b00;
      fall_p2 <= 2'b00;
      chg_p2  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_p2[i]  <= st_nxt[i];
        cnt_p2[i] <= cnt_nxt[i];
      end
      rise_p2 <= rise_nxt;
      fall_p2 <= fall_nxt;
      chg_p2  <= |{rise_nxt, fall_nxt};
    end
  end

  assign a_rise = rise_p2[0];
  assign a_fall = fall_p2[0];
  assign b_rise = rise_p2[1];
  assign b_fall = fall_p2[1];
  assign chg    = chg_p2;

`ifdef SW_TOGGLE_EN
  // Toggle latches follow debounced presses; strobes still report switch edges.
  logic [1:0] tog_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_p2 <= 2'b00;
    end else begin
      tog_p2 <= tog_p2 ^ rise_nxt;
    end
  end

  assign a = tog_p2[0];
  assign b = tog_p2[1];
`else
  assign a = (st_p2[0] == HIGH);
  assign b = (st_p2[1] == HIGH);
`endif

endmodule

// File: tb/tb_sw_debounce2.sv
// Bench for sw_debounce2 with STABLE_CNT=4: segment-built vector table, hand-placed edge events, scoreboard queue.
module tb_sw_debounce2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw_a_in = 1'b0;
  logic sw_b_in = 1'b0;
  logic a, b, a_rise, a_fall, b_rise, b_fall, chg;

`ifdef SW_TOGGLE_EN
  localparam bit TOGGLE = 1'b1;
`else
  localparam bit TOGGLE = 1'b0;
`endif

  localparam int NROWS = 64;
  localparam int NSEG  = 10;
  localparam int NEV   = 9;

  sw_debounce2 #(.CNT_W(4), .STABLE_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw_a_in(sw_a_in), .sw_b_in(sw_b_in),
    .a(a), .b(b), .a_rise(a_rise), .a_fall(a_fall),
    .b_rise(b_rise), .b_fall(b_fall), .chg(chg)
  );

  always #5 clk = ~clk;

  typedef struct { int len; logic sa; logic sb; } seg_t;
  typedef struct { int row; bit ch; bit rise; } ev_t;
  // exp packs {a, b, a_rise, a_fall, b_rise, b_fall, chg}
  typedef struct { logic sa; logic sb; logic [6:0] exp; } vec_t;

  seg_t       segs [NSEG];
  ev_t        evs  [NEV];
  vec_t       vecs [NROWS];
  logic [6:0] sbq  [$];
  int checks = 0;
  int errors = 0;

  task automatic check_out(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {a, b, a_rise, a_fall, b_rise, b_fall, chg};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s {a,b,a_rise,a_fall,b_rise,b_fall,chg} got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; drives inputs, samples just after the next rising edge.
  task automatic step(input logic sa, input logic sb, input logic [6:0] exp, input string name);
    sw_a_in = sa;
    sw_b_in = sb;
    sbq.push_back(exp);
    @(posedge clk);
    #1;
    check_out(name, sbq.pop_front());
    @(negedge clk);
  endtask

  initial begin
    int r;
    logic la, lb, ta, tb;
    logic ar, af, br, bf, oa, ob;
    logic [6:0] hold;

    // Stimulus segments: {length, sw_a_in, sw_b_in}; rows start at 0,2,12,22,25,26,34,42,50,57.
    segs[0] = '{2, 1'b0, 1'b0};
    segs[1] = '{10, 1'b1, 1'b0};  // A rises
    segs[2] = '{10, 1'b0, 1'b0};  // A falls, B untouched
    segs[3] = '{3, 1'b1, 1'b0};   // A bounce: 3 high
    segs[4] = '{1, 1'b0, 1'b0};   //   1 low
    segs[5] = '{8, 1'b1, 1'b0};   //   then held high
    segs[6] = '{8, 1'b0, 1'b0};
    segs[7] = '{8, 1'b1, 1'b1};   // simultaneous A and B rise
    segs[8] = '{7, 1'b0, 1'b1};   // A falls while B stays high
    segs[9] = '{7, 1'b1, 1'b0};   // A rise and B fall on the same edge

    // Debounced edges appear 5 rows after the row that first carries the new level.
    evs[0] = '{7, 1'b0, 1'b1};
    evs[1] = '{17, 1'b0, 1'b0};
    evs[2] = '{31, 1'b0, 1'b1};
    evs[3] = '{39, 1'b0, 1'b0};
    evs[4] = '{47, 1'b0, 1'b1};
    evs[5] = '{47, 1'b1, 1'b1};
    evs[6] = '{55, 1'b0, 1'b0};
    evs[7] = '{62, 1'b0, 1'b1};
    evs[8] = '{62, 1'b1, 1'b0};

    r = 0;
    for (int s = 0; s < NSEG; s++) begin
      for (int j = 0; j < segs[s].len; j++) begin
        vecs[r].sa = segs[s].sa;
        vecs[r].sb = segs[s].sb;
        r++;
      end
    end

    la = 1'b0; lb = 1'b0; ta = 1'b0; tb = 1'b0;
    for (int i = 0; i < NROWS; i++) begin
      ar = 1'b0; af = 1'b0; br = 1'b0; bf = 1'b0;
      for (int e = 0; e < NEV; e++) begin
        if (evs[e].row == i) begin
          if (evs[e].ch == 1'b0) begin
            if (evs[e].rise) begin ar = 1'b1; la = 1'b1; ta = ~ta; end
            else begin af = 1'b1; la = 1'b0; end
          end else begin
            if (evs[e].rise) begin br = 1'b1; lb = 1'b1; tb = ~tb; end
            else begin bf = 1'b1; lb = 1'b0; end
          end
        end
      end
      oa = TOGGLE ? ta : la;
      ob = TOGGLE ? tb : lb;
      vecs[i].exp = {oa, ob, ar, af, br, bf, (ar | af | br | bf)};
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset_state", 7'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NROWS; i++)
      step(vecs[i].sa, vecs[i].sb, vecs[i].exp, $sformatf("row%0d", i));

    // Build a partial count of 2 contrary samples on A, then reset asynchronously mid-cycle.
    hold = {vecs[NROWS-1].exp[6:5], 5'b0};
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, hold, $sformatf("pre_rst%0d", i));
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 7'b0);
    sw_a_in = 1'b1;
    @(posedge clk);
    #1;
    check_out("rst_hold", 7'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b0, (i == 5) ? 7'b1010001 : ((i > 5) ? 7'b1000000 : 7'b0000000),
           $sformatf("rst_rel%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce2.md
# sw_debounce2

Two-channel switch conditioning stage that feeds the two-input logic-gate block on the board. It takes raw, asynchronous, bouncing slide-switch or push-button levels and performs three steps:
- synchronises each channel into the system clock;
- filters each channel with a per-channel stability counter;
- drives clean `a`/`b` levels plus single-cycle edge strobes.

The gate block consumes `a` and `b` directly. The strobes are for any stage that counts or logs input changes.

## Interface
Parameters:
- `CNT_W`, 20: width of each per-channel stability counter.
- `STABLE_CNT`, 1000000: consecutive synchronised samples required before the output follows (20 ms at 50 MHz). Legal range is 1 ≤ STABLE_CNT ≤ 2^CNT_W − 1.

Ports:
- `clk`, input, 1: system clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `sw_a_in`, input, 1: raw switch A, asynchronous to `clk`.
- `sw_b_in`, input, 1: raw switch B, asynchronous to `clk`.
- `a`, output, 1: debounced (or toggled, see Configuration) channel A level; registered.
- `b`, output, 1: debounced (or toggled) channel B level; registered.
- `a_rise`, `a_fall`, output, 1 each: one-cycle strobes on debounced A edges.
- `b_rise`, `b_fall`, output, 1 each: one-cycle strobes on debounced B edges.
- `chg`, output, 1: OR of all four strobes, registered in the same cycle as the strobes.

## Operation
- Each channel has a 2-flop synchroniser (`s1` → `s2`), a debounced level register `lvl`, and a counter `cnt`.
- Channel state machine:
  - LOW: `lvl`=0. The counter advances while `s2`=1 and clears to 0 on any cycle with `s2`=0.
  - LOW → HIGH: on the edge where `s2`=1 and `cnt`==STABLE_CNT−1. On that edge, `lvl`←1, `cnt`←0, and the rise strobe asserts.
  - HIGH: mirror image of LOW. It returns to LOW on STABLE_CNT consecutive `s2`=0 samples, and the fall strobe asserts.
- Any single contrary sample clears `cnt`. A bounce shorter than STABLE_CNT samples therefore never changes `lvl` and produces no strobe.
- Channels A and B are fully independent. Both may change, and both may strobe, on the same edge.
- The counter never exceeds STABLE_CNT−1, so there is no wrap-around.
- Reset (asynchronous, any time, including mid-count):
  - `s1`, `s2`, `lvl`, `cnt`, the toggle state, all strobes, and `chg` go to 0 immediately.
  - `a`=`b`=0.
- After reset release with a switch held high, the channel debounces from LOW as normal. It produces a rise strobe and goes high after the standard latency.

## Timing
- Input level change first captured by `s1` at edge k: `s2` reflects it at edge k+1, and `lvl`/strobe update at edge k+1+STABLE_CNT. Total latency is STABLE_CNT+1 cycles from the capturing edge.
- Strobes are exactly one cycle wide and coincide with the cycle in which the output first shows the new value.
- Back-to-back transitions of one channel are at least STABLE_CNT cycles apart.
- No combinational path from any input to any output.

## Configuration
- `SW_TOGGLE_EN` defined:
  - `a`/`b` are toggle latches that invert on every debounced rising edge of their channel. Falling edges leave them unchanged.
  - Rise/fall strobes and `chg` still report debounced switch edges, not output changes.
  - The toggle state resets to 0.
- `SW_TOGGLE_EN` undefined: `a`/`b` equal the debounced levels directly.

## Test plan
All scenarios use STABLE_CNT=4.
- Reset, then `sw_a_in` 0→1 held, captured at edge k:
  - `a`=1 and `a_rise`=1 (for one cycle only) and `chg`=1 at edge k+5.
  - `a`=0 at edges k+1..k+4.
- Bounce on A: 1 for 3 cycles, 0 for 1 cycle, then 1 held:
  - No output change until 4 consecutive high samples.
  - Exactly one `a_rise` in total.
- Simultaneous A and B 0→1 on the same edge: `a`, `b`, `a_rise`, `b_rise` all assert on the same edge; `chg` is a single one-cycle pulse.
- A high and stable, then 1→0 held: `a` falls 5 edges later with one `a_fall` pulse; `b` is unaffected throughout.
- `rst_n` asserted while `cnt`=2 and while `a`=1:
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release with the switch still high, `a` returns to 1 exactly 5 edges after the first capturing edge.
- With `SW_TOGGLE_EN`, three press/release cycles on A:
  - `a` goes 1, 0, 1 on the three debounced rises.
  - Three `a_rise` and three `a_fall` pulses are seen.
